// File: rtl/airlock_pkg.sv
// Shared airlock types and default pressure thresholds,
// used by the arrival and departure workflows.
package airlock_pkg;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_SEAL       = 4'd1,
    S_EVAC       = 4'd2,
    S_OUTER_OPEN = 4'd3,
    S_DOCK       = 4'd4,
    S_FILL       = 4'd5,
    S_INNER_OPEN = 4'd6,
    S_EXIT       = 4'd7,
    S_DONE       = 4'd8,
    S_ABORT      = 4'd9
  } state_t;

  localparam logic [7:0] AIR_LOW_P   = 8'd10;
  localparam logic [7:0] AIR_HIGH_LO = 8'd90;
  localparam logic [7:0] AIR_HIGH_HI = 8'd110;

endpackage

// File: rtl/arrival_workflow_start_edge.sv
// Start rise detector. A start held high through reset release
// must go low once before it can register a rise.
module start_edge (
  input  logic clock,
  input  logic reset,
  input  logic start,
  output logic rise
);

  logic r_start;
  logic r_armed;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_start <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_start <= start;
      r_armed <= r_armed | ~start;
    end
  end

  assign rise = start & ~r_start & r_armed;

endmodule

// File: rtl/arrival_workflow.sv
// Airlock arrival sequencer: seal, evacuate, dock, refill, exit.
// Optional pump-phase timeout abort under ARRIVAL_TIMEOUT_EN.
module arrival_workflow
  import airlock_pkg::*;
#(
  parameter logic [7:0] LOW_P   = AIR_LOW_P,
  parameter logic [7:0] HIGH_LO = AIR_HIGH_LO,
  parameter logic [7:0] HIGH_HI = AIR_HIGH_HI
`ifdef ARRIVAL_TIMEOUT_EN
  ,
  parameter logic [7:0] TIMEOUT_TICKS = 8'd12
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       five_sec,
  input  logic       od_closed,
  input  logic       id_closed,
  input  logic [7:0] pressure,
  output logic       busy,
  output logic       start_pressurizing,
  output logic       start_depressurizing,
  output logic       done,
  output logic       fault,
  output logic [3:0] state
);

  state_t r_state;
  logic   r_busy;
  logic   r_pres;
  logic   r_dep;
  logic   r_done;
  logic   w_rise;
  logic   w_low;
  logic   w_high;
  logic   w_over;

  start_edge u_start_edge (
    .clock (clock),
    .reset (reset),
    .start (start),
    .rise  (w_rise)
  );

  assign w_low  = pressure < LOW_P;
  assign w_high = (pressure > HIGH_LO) && (pressure < HIGH_HI);
  assign w_over = pressure >= HIGH_HI;

`ifdef ARRIVAL_TIMEOUT_EN
  logic       r_fault;
  logic [7:0] r_cnt;
  logic       w_tmo;

  assign w_tmo = five_sec && (r_cnt + 8'd1 == TIMEOUT_TICKS);
  assign fault = r_fault;
`else
  assign fault = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_pres  <= 1'b0;
      r_dep   <= 1'b0;
      r_done  <= 1'b0;
`ifdef ARRIVAL_TIMEOUT_EN
      r_fault <= 1'b0;
      r_cnt   <= 8'd0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: if (w_rise) begin
          r_state <= S_SEAL;
          r_busy  <= 1'b1;
        end
        S_SEAL: if (od_closed && id_closed) begin
          if (w_low) begin
            r_state <= S_OUTER_OPEN;
          end else begin
            r_state <= S_EVAC;
            r_dep   <= 1'b1;
`ifdef ARRIVAL_TIMEOUT_EN
            r_cnt   <= 8'd0;
`endif
          end
        end
        S_EVAC: begin
          if (w_low) begin
            r_state <= S_OUTER_OPEN;
            r_dep   <= 1'b0;
          end
`ifdef ARRIVAL_TIMEOUT_EN
          else if (w_tmo) begin
            r_state <= S_ABORT;
            r_dep   <= 1'b0;
            r_fault <= 1'b1;
          end else if (five_sec) begin
            r_cnt <= r_cnt + 8'd1;
          end
`endif
        end
        S_OUTER_OPEN: if (!od_closed && five_sec) begin
          r_state <= S_DOCK;
        end
        S_DOCK: if (od_closed) begin
          r_state <= S_FILL;
          r_pres  <= 1'b1;
`ifdef ARRIVAL_TIMEOUT_EN
          r_cnt   <= 8'd0;
`endif
        end
        S_FILL: begin
          if (w_high) begin
            r_state <= S_INNER_OPEN;
            r_pres  <= 1'b0;
            r_dep   <= 1'b0;
          end
`ifdef ARRIVAL_TIMEOUT_EN
          else if (w_tmo) begin
            r_state <= S_ABORT;
            r_pres  <= 1'b0;
            r_dep   <= 1'b0;
            r_fault <= 1'b1;
          end
`endif
          else begin
            // overshoot: vent until back inside the window
            if (w_over) begin
              r_pres <= 1'b0;
              r_dep  <= 1'b1;
            end
`ifdef ARRIVAL_TIMEOUT_EN
            if (five_sec) r_cnt <= r_cnt + 8'd1;
`endif
          end
        end
        S_INNER_OPEN: if (!id_closed) begin
          r_state <= S_EXIT;
        end
        S_EXIT: if (id_closed) begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
`ifdef ARRIVAL_TIMEOUT_EN
        S_ABORT: if (w_rise) begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_fault <= 1'b0;
        end
`endif
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_pres  <= 1'b0;
          r_dep   <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy                 = r_busy;
  assign start_pressurizing   = r_pres;
  assign start_depressurizing = r_dep;
  assign done                 = r_done;
  assign state                = r_state;

endmodule

// File: tb/tb_arrival_workflow.sv
// Arrival workflow bench: directed scenarios then random
// stimulus, every cycle compared against a behavioural model.
module tb_arrival_workflow;
  import airlock_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       five_sec = 1'b0;
  logic       od_closed = 1'b1;
  logic       id_closed = 1'b1;
  logic [7:0] pressure = 8'd100;
  logic       busy;
  logic       start_pressurizing;
  logic       start_depressurizing;
  logic       done;
  logic       fault;
  logic [3:0] state;

  int total = 0;
  int bad = 0;

  arrival_workflow dut (
    .clock                (clock),
    .reset                (reset),
    .start                (start),
    .five_sec             (five_sec),
    .od_closed            (od_closed),
    .id_closed            (id_closed),
    .pressure             (pressure),
    .busy                 (busy),
    .start_pressurizing   (start_pressurizing),
    .start_depressurizing (start_depressurizing),
    .done                 (done),
    .fault                (fault),
    .state                (state)
  );

  always #5 clock = ~clock;

`ifdef ARRIVAL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TICKS = 12;

  // model state
  state_t m_ph;
  bit m_busy, m_pres, m_dep, m_done, m_fault;
  bit m_prev, m_armed;
  int m_cnt;
  int done_seen;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_ph = S_IDLE;
    m_busy = 0; m_pres = 0; m_dep = 0;
    m_done = 0; m_fault = 0;
    m_prev = 0; m_armed = 0; m_cnt = 0;
  endfunction

  function automatic void model_step(bit st, bit fv, bit od, bit id, int p);
    bit rise;
    bit low, high, over;
    rise = st && !m_prev && m_armed;
    m_prev = st;
    if (!st) m_armed = 1;
    low  = p < 10;
    high = p > 90 && p < 110;
    over = p >= 110;
    if (m_ph == S_IDLE) begin
      if (rise) begin m_ph = S_SEAL; m_busy = 1; end
    end else if (m_ph == S_SEAL) begin
      if (od && id) begin
        if (low) m_ph = S_OUTER_OPEN;
        else begin m_ph = S_EVAC; m_dep = 1; m_cnt = 0; end
      end
    end else if (m_ph == S_EVAC) begin
      if (low) begin m_ph = S_OUTER_OPEN; m_dep = 0; end
      else if (TO_EN && fv) begin
        m_cnt++;
        if (m_cnt == TICKS) begin
          m_ph = S_ABORT; m_dep = 0; m_fault = 1;
        end
      end
    end else if (m_ph == S_OUTER_OPEN) begin
      if (!od && fv) m_ph = S_DOCK;
    end else if (m_ph == S_DOCK) begin
      if (od) begin m_ph = S_FILL; m_pres = 1; m_cnt = 0; end
    end else if (m_ph == S_FILL) begin
      if (high) begin
        m_ph = S_INNER_OPEN; m_pres = 0; m_dep = 0;
      end else begin
        if (over) begin m_pres = 0; m_dep = 1; end
        if (TO_EN && fv) begin
          m_cnt++;
          if (m_cnt == TICKS) begin
            m_ph = S_ABORT; m_pres = 0; m_dep = 0; m_fault = 1;
          end
        end
      end
    end else if (m_ph == S_INNER_OPEN) begin
      if (!id) m_ph = S_EXIT;
    end else if (m_ph == S_EXIT) begin
      if (id) begin m_ph = S_DONE; m_done = 1; m_busy = 0; end
    end else if (m_ph == S_DONE) begin
      m_ph = S_IDLE; m_done = 0;
    end else if (m_ph == S_ABORT) begin
      if (rise) begin m_ph = S_IDLE; m_busy = 0; m_fault = 0; end
    end
  endfunction

  task automatic compare_all(input string pfx);
    check({pfx, ".state"}, int'(state), int'(m_ph));
    check({pfx, ".busy"}, int'(busy), int'(m_busy));
    check({pfx, ".pres"}, int'(start_pressurizing), int'(m_pres));
    check({pfx, ".dep"}, int'(start_depressurizing), int'(m_dep));
    check({pfx, ".done"}, int'(done), int'(m_done));
    check({pfx, ".fault"}, int'(fault), int'(m_fault));
    check({pfx, ".excl"},
          int'(start_pressurizing && start_depressurizing), 0);
  endtask

  task automatic tick(input bit st, input bit fv, input bit od,
                      input bit id, input int p);
    @(negedge clock);
    start = st; five_sec = fv;
    od_closed = od; id_closed = id;
    pressure = 8'(p);
    @(posedge clock);
    model_step(st, fv, od, id, p);
    #1;
    if (done) done_seen++;
    compare_all("cyc");
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    model_reset();
    compare_all("rst");
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int p_tab[13] = '{3, 5, 9, 10, 50, 89, 90, 91, 100, 109, 110, 120, 255};

    model_reset();
    do_reset();

    // nominal arrival
    tick(0, 0, 1, 1, 100);
    tick(1, 0, 1, 1, 100);
    check("nom.seal", int'(state), int'(S_SEAL));
    tick(0, 0, 1, 1, 100);
    check("nom.evac_dep", int'(start_depressurizing), 1);
    // busy guard: start pulses in EVAC ignored
    tick(1, 0, 1, 1, 50);
    tick(0, 0, 1, 1, 50);
    tick(1, 0, 1, 1, 50);
    check("guard.evac", int'(state), int'(S_EVAC));
    tick(0, 0, 1, 1, 5);
    check("nom.outer", int'(state), int'(S_OUTER_OPEN));
    tick(0, 1, 0, 1, 5);
    check("nom.dock", int'(state), int'(S_DOCK));
    tick(0, 0, 1, 1, 5);
    check("nom.fill_pres", int'(start_pressurizing), 1);
    tick(0, 0, 1, 1, 100);
    check("nom.inner", int'(state), int'(S_INNER_OPEN));
    tick(0, 0, 1, 0, 100);
    done_seen = 0;
    tick(0, 0, 1, 1, 100);
    check("nom.done", int'(done), 1);
    check("nom.busy0", int'(busy), 0);
    tick(0, 0, 1, 1, 100);
    check("nom.done_1cyc", done_seen, 1);
    check("nom.idle", int'(state), int'(S_IDLE));

    // pre-evacuated chamber skips EVAC
    tick(1, 0, 1, 1, 3);
    tick(0, 0, 1, 1, 3);
    check("pre.outer", int'(state), int'(S_OUTER_OPEN));
    check("pre.dep0", int'(start_depressurizing), 0);

    // overshoot during FILL
    tick(0, 1, 0, 1, 3);
    tick(0, 0, 1, 1, 40);
    tick(0, 0, 1, 1, 120);
    check("ovr.pres0", int'(start_pressurizing), 0);
    check("ovr.dep1", int'(start_depressurizing), 1);
    tick(0, 0, 1, 1, 95);
    check("ovr.inner", int'(state), int'(S_INNER_OPEN));
    check("ovr.dep0", int'(start_depressurizing), 0);
    tick(0, 0, 1, 0, 95);
    tick(0, 0, 1, 1, 95);
    tick(0, 0, 1, 1, 95);

    // reset mid-FILL with start held high through release
    tick(1, 0, 1, 1, 100);
    tick(0, 0, 1, 1, 100);
    tick(0, 0, 1, 1, 5);
    tick(0, 1, 0, 1, 5);
    tick(1, 0, 1, 1, 50);
    check("rmf.fill", int'(state), int'(S_FILL));
    done_seen = 0;
    do_reset();
    check("rmf.pres0", int'(start_pressurizing), 0);
    tick(1, 0, 1, 1, 50);
    tick(1, 0, 1, 1, 50);
    check("rmf.held", int'(state), int'(S_IDLE));
    check("rmf.nodone", done_seen, 0);
    tick(0, 0, 1, 1, 50);
    tick(1, 0, 1, 1, 50);
    check("rmf.restart", int'(state), int'(S_SEAL));

    // stuck pressure in EVAC: timeout abort when enabled
    tick(0, 0, 1, 1, 50);
    for (int i = 0; i < TICKS; i++) tick(0, 1, 1, 1, 50);
    check("tmo.state", int'(state), TO_EN ? int'(S_ABORT) : int'(S_EVAC));
    check("tmo.fault", int'(fault), TO_EN ? 1 : 0);
    tick(1, 0, 1, 1, 5);
    tick(0, 0, 1, 1, 5);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else
        tick($urandom_range(0, 7) == 0,
             $urandom_range(0, 3) == 0,
             $urandom_range(0, 3) != 0,
             $urandom_range(0, 3) != 0,
             ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 255))
                                         : p_tab[$urandom_range(0, 12)]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arrival_workflow.md
ARRIVAL_WORKFLOW -- requirements
Module: arrival_workflow

Interface
REQ-001 Parameter LOW_P, default 8'd10, vacuum threshold; pressure < LOW_P counts as evacuated.
REQ-002 Parameter HIGH_LO, default 8'd90, exclusive lower bound of the habitable pressure window.
REQ-003 Parameter HIGH_HI, default 8'd110, exclusive upper bound of the habitable pressure window.
REQ-004 Parameter TIMEOUT_TICKS, default 8'd12, number of five_sec ticks allowed per pump phase; used only with ARRIVAL_TIMEOUT_EN.
REQ-005 clock  in  1  system clock; all state changes on the rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  arrival request, level or pulse.
REQ-008 five_sec  in  1  one-cycle tick from the external 5-second timer.
REQ-009 od_closed, id_closed  in  1 each  outer door closed, inner door closed.
REQ-010 pressure  in  8  unsigned chamber pressure.
REQ-011 busy  out  1  workflow in progress.
REQ-012 start_pressurizing, start_depressurizing  out  1 each  pump commands, registered.
REQ-013 done  out  1  one-cycle pulse on workflow completion.
REQ-014 fault  out  1  timeout abort flag.
REQ-015 state  out  4  current state encoding, for debug.

Function
REQ-016 Definitions: low = pressure < LOW_P; high = HIGH_LO < pressure < HIGH_HI; over = pressure >= HIGH_HI.
REQ-017 States: IDLE, SEAL, EVAC, OUTER_OPEN, DOCK, FILL, INNER_OPEN, EXIT, DONE. At most one transition per cycle.
REQ-018 IDLE: on the start edge -> SEAL, with busy=1 registered in the same edge; start is ignored in every other state.
REQ-019 SEAL: when od_closed and id_closed are both 1 -> EVAC with start_depressurizing=1; if low already holds on that cycle, go directly to OUTER_OPEN with both pumps 0.
REQ-020 EVAC: when low -> OUTER_OPEN, start_depressurizing=0.
REQ-021 OUTER_OPEN: when !od_closed and five_sec on the same cycle -> DOCK.
REQ-022 DOCK: when od_closed -> FILL with start_pressurizing=1.
REQ-023 FILL: when high -> INNER_OPEN, start_pressurizing=0; if over, drive start_pressurizing=0 and start_depressurizing=1 until high holds.
REQ-024 INNER_OPEN: when !id_closed -> EXIT.
REQ-025 EXIT: when id_closed -> DONE.
REQ-026 DONE: for exactly one cycle, done=1 and busy=0 registered on the exit edge; then -> IDLE.
REQ-027 start_pressurizing and start_depressurizing SHALL never be 1 on the same cycle.
REQ-028 Any condition not met holds state and all outputs unchanged.
REQ-029 The start edge is taken from sub-module start_edge (registered start, rise detect), giving 1 cycle of latency from the start rise to leaving IDLE.

Reset
REQ-030 reset=1 forces state=IDLE, busy=0, both pumps=0, done=0, fault=0, timeout counter=0, and edge register=0 immediately, independent of clock.
REQ-031 Reset asserted mid-workflow (any state) SHALL abort with no done pulse; reset wins over a simultaneous start.

Configuration
REQ-032 Macro ARRIVAL_TIMEOUT_EN defined: an 8-bit counter clears on entry to EVAC/FILL and increments on five_sec in those states; on reaching TIMEOUT_TICKS -> ABORT state (pumps 0, busy=1, fault=1). ABORT -> IDLE on the next start edge, clearing fault and busy.
REQ-033 Macro ARRIVAL_TIMEOUT_EN undefined: no counter and no ABORT state; fault tied to 0; EVAC/FILL wait indefinitely.

Structure
REQ-034 Shared package airlock_pkg SHALL hold the state enum typedef (4-bit, including ABORT) and the default pressure constants (10, 90, 110), shared with the departure workflow.
REQ-035 One sub-module, start_edge; all else in arrival_workflow.

Verification
REQ-036 Nominal: pressure=100, doors closed, start pulse -> SEAL, EVAC with depressurize=1; pressure=5 -> OUTER_OPEN; od_closed=0 with five_sec -> DOCK; od_closed=1 -> pressurize=1; pressure=100 -> INNER_OPEN; id open then closed -> done pulse 1 cycle, busy=0.
REQ-037 Pre-evacuated: pressure=3 at SEAL with both doors closed -> OUTER_OPEN directly, depressurize never asserted.
REQ-038 Overshoot: pressure=120 in FILL -> pressurize=0, depressurize=1; pressure=95 -> INNER_OPEN with both pumps 0.
REQ-039 Reset mid-FILL: reset=1 -> outputs clear asynchronously, state=IDLE, no done pulse; a start held high through reset release does not trigger until it goes low and then high again.
REQ-040 With ARRIVAL_TIMEOUT_EN: pressure stuck at 50 in EVAC with 12 five_sec ticks -> ABORT, fault=1, pumps 0; next start -> IDLE, fault=0.
REQ-041 Busy guard: start pulses during EVAC -> ignored; state sequence unchanged.
